csr_access_unit: RTL and testbench

Core-side initiator for the machine-mode CSR file. Accepts one decoded Zicsr instruction (CSRRW/RS/RC and immediate forms) from the execute stage. Sequences the read, modify and write commands over the CSR command interface. Returns the old CSR value, or an illegal-instruction flag, to the pipeline through a valid/ready response.

---
 rtl/csr_access_unit.sv | 145 ++++++++++++++
 tb/tb_csr_access_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences Zicsr read/modify/write commands to the M-mode CSR file.
// Build macro CSR_WRITE_ELISION_EN skips RS/RC writes that leave the CSR unchanged. Command: 0 NONE, 1 READ_ONLY, 2 WRITE_ONLY.
module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [11:0]     req_address_i,
    input  logic [XLEN-1:0] req_rs1_data_i,
    input  logic [4:0]      req_rs1_field_i,
    input  logic            req_rd_is_x0_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_illegal_o,
    output logic [11:0]     csr_address_o,
    output logic [1:0]      csr_command_o,
    output logic [XLEN-1:0] csr_write_data_o,
    input  logic [XLEN-1:0] csr_read_data_i,
    input  logic            csr_read_data_valid_i
);
    localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, CAPTURE = 3'd2, WRITE = 3'd3, RESPOND = 3'd4;
    localparam logic [1:0] CMD_NONE = 2'd0, CMD_READ = 2'd1, CMD_WRITE = 2'd2;
    localparam logic [1:0] OP_RW = 2'd1, OP_RS = 2'd2;

    logic [2:0]      state_q, state_d;
    logic [1:0]      op_q, op_d, cmd_q, cmd_d;
    logic [XLEN-1:0] operand_q, operand_d, old_q, old_d, wdata_q, wdata_d;
    logic [11:0]     addr_q, addr_d;
    logic            do_read_q, do_read_d, do_write_q, do_write_d, wr_ill_q, wr_ill_d, ill_q, ill_d;
    logic [XLEN-1:0] req_operand, new_val;
    logic            req_rw, req_do_read, req_do_write, elide;

    assign req_rw       = req_funct3_i[1:0] == OP_RW;
    assign req_operand  = req_funct3_i[2] ? XLEN'(req_rs1_field_i) : req_rs1_data_i;
    assign req_do_read  = !(req_rw && req_rd_is_x0_i);
    assign req_do_write = req_rw || req_rs1_field_i != 5'd0;
    assign new_val = op_q == OP_RW ? operand_q :
                     op_q == OP_RS ? (csr_read_data_i | operand_q) : (csr_read_data_i & ~operand_q);

`ifdef CSR_WRITE_ELISION_EN
    assign elide = op_q != OP_RW && new_val == csr_read_data_i;
`else
    assign elide = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        operand_d  = operand_q;
        do_read_d  = do_read_q;
        do_write_d = do_write_q;
        wr_ill_d   = wr_ill_q;
        old_d      = old_q;
        ill_d      = ill_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cmd_d      = CMD_NONE;
        case (state_q)
            IDLE: if (req_valid_i && !flush_i) begin
                op_d       = req_funct3_i[1:0];
                operand_d  = req_operand;
                do_read_d  = req_do_read;
                do_write_d = req_do_write;
                wr_ill_d   = req_do_write && req_address_i[11:10] == 2'b11;
                addr_d     = req_address_i;
                old_d      = '0;
                ill_d      = req_funct3_i[1:0] == 2'b00;
                state_d    = ill_d ? RESPOND : CHECK;
                cmd_d      = (!ill_d && req_do_read) ? CMD_READ : CMD_NONE;
            end
            CHECK: if (flush_i) begin
                state_d = IDLE;
            end else if (!csr_read_data_valid_i || wr_ill_q) begin
                state_d = RESPOND;
                ill_d   = 1'b1;
            end else if (do_read_q) begin
                state_d = CAPTURE;
            end else begin
                state_d = WRITE;
                cmd_d   = CMD_WRITE;
                wdata_d = operand_q;
            end
            CAPTURE: if (flush_i) begin
                state_d = IDLE;
            end else begin
                old_d = csr_read_data_i;
                if (do_write_q && !elide) begin
                    state_d = WRITE;
                    cmd_d   = CMD_WRITE;
                    wdata_d = new_val;
                end else begin
                    state_d = RESPOND;
                end
            end
            WRITE: state_d = RESPOND;
            RESPOND: if (rsp_ready_i) begin
                state_d = IDLE;
                old_d   = '0;
                ill_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            operand_q  <= '0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
            wr_ill_q   <= 1'b0;
            old_q      <= '0;
            ill_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cmd_q      <= CMD_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            do_read_q  <= do_read_d;
            do_write_q <= do_write_d;
            wr_ill_q   <= wr_ill_d;
            old_q      <= old_d;
            ill_q      <= ill_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cmd_q      <= cmd_d;
        end
    end

    assign req_ready_o      = state_q == IDLE;
    assign rsp_valid_o      = state_q == RESPOND;
    assign rsp_data_o       = old_q;
    assign rsp_illegal_o    = ill_q;
    assign csr_address_o    = addr_q;
    assign csr_command_o    = cmd_q;
    assign csr_write_data_o = wdata_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: CSR file environment plus a latency/value model of each Zicsr request.
// Honours CSR_WRITE_ELISION_EN the same way the design does.
module tb_csr_access_unit;
    localparam logic [1:0] C_NONE = 2'd0, C_READ = 2'd1, C_WRITE = 2'd2;
`ifdef CSR_WRITE_ELISION_EN
    localparam bit ELIDE = 1'b1;
`else
    localparam bit ELIDE = 1'b0;
`endif

    logic        clock_i = 0, reset_i = 0;
    logic        req_valid_i = 0, req_ready_o;
    logic [2:0]  req_funct3_i = 0;
    logic [11:0] req_address_i = 0;
    logic [31:0] req_rs1_data_i = 0;
    logic [4:0]  req_rs1_field_i = 0;
    logic        req_rd_is_x0_i = 0, flush_i = 0;
    logic        rsp_valid_o, rsp_ready_i = 0, rsp_illegal_o;
    logic [31:0] rsp_data_o;
    logic [11:0] csr_address_o;
    logic [1:0]  csr_command_o;
    logic [31:0] csr_write_data_o, csr_read_data_i;
    logic        csr_read_data_valid_i;

    csr_access_unit #(.XLEN(32)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_address_i(req_address_i),
        .req_rs1_data_i(req_rs1_data_i), .req_rs1_field_i(req_rs1_field_i),
        .req_rd_is_x0_i(req_rd_is_x0_i), .flush_i(flush_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_illegal_o(rsp_illegal_o),
        .csr_address_o(csr_address_o), .csr_command_o(csr_command_o),
        .csr_write_data_o(csr_write_data_o), .csr_read_data_i(csr_read_data_i),
        .csr_read_data_valid_i(csr_read_data_valid_i)
    );

    always #5 clock_i = ~clock_i;

    // CSR file environment: registered reads, writes on WRITE_ONLY, backdoor preload
    logic [31:0] env_mem [4096];
    bit          env_exists [4096];
    logic [31:0] model_csr [4096];
    int          wr_count = 0;
    logic        bd_we = 0;
    logic [11:0] bd_a = 0;
    logic [31:0] bd_d = 0;
    logic [11:0] addr_tab [8] = '{12'h340, 12'h304, 12'h300, 12'h341, 12'hF14, 12'hC00, 12'h7C0, 12'h305};

    assign csr_read_data_valid_i = env_exists[csr_address_o];

    always @(posedge clock_i) begin
        if (csr_command_o == C_READ) csr_read_data_i <= env_mem[csr_address_o];
        if (csr_command_o == C_WRITE) begin
            env_mem[csr_address_o] <= csr_write_data_o;
            wr_count <= wr_count + 1;
        end
        if (bd_we) env_mem[bd_a] <= bd_d;
    end

    int          checks = 0, fails = 0;
    bit          busy = 0;
    int          cyc = 0, e_lat = 0;
    bit          e_rd = 0, e_wr = 0, e_ill = 0;
    logic [31:0] e_data = 0, e_wdata = 0;
    logic [11:0] e_addr = 0;
    logic [1:0]  exp_cmd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare: cyc counts cycles since the accepting edge
    always @(negedge clock_i) begin
        if (!reset_i) begin
            if (busy) cyc++;
            chk("req_ready", req_ready_o, !busy);
            chk("rsp_valid", rsp_valid_o, busy && cyc >= e_lat);
            if (busy && cyc >= e_lat) begin
                chk("rsp_data", rsp_data_o, e_data);
                chk("rsp_illegal", rsp_illegal_o, e_ill);
            end
            exp_cmd = !busy ? C_NONE : (e_rd && cyc == 1) ? C_READ : (e_wr && cyc == e_lat - 1) ? C_WRITE : C_NONE;
            chk("csr_command", csr_command_o, exp_cmd);
            if (exp_cmd != C_NONE) chk("csr_address", csr_address_o, e_addr);
            if (exp_cmd == C_WRITE) chk("csr_write_data", csr_write_data_o, e_wdata);
        end
    end

    task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
        @(negedge clock_i);
        bd_we = 1; bd_a = a; bd_d = v;
        @(posedge clock_i); #1;
        bd_we = 0;
        model_csr[a] = v;
    endtask

    task automatic apply_reset();
        busy = 0;
        @(negedge clock_i); #2;
        reset_i = 1;
        @(posedge clock_i); #2;
        reset_i = 0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d,
                          input logic [4:0] fld, input bit x0, input int flush_at, input int stall);
        logic [1:0]  op;
        logic [31:0] opnd, old, nv;
        bit          rw, dr, dw, legal, ok, dropped, got;
        int          n;
        op = f[1:0];
        legal = op != 2'd0;
        rw = op == 2'd1;
        opnd = f[2] ? {27'd0, fld} : d;
        dr = !(rw && x0);
        dw = rw || fld != 5'd0;
        old = model_csr[a];
        ok = legal && env_exists[a] && !(dw && a[11:10] == 2'b11);
        nv = rw ? opnd : (op == 2'd2) ? (old | opnd) : (old & ~opnd);
        e_addr = a;
        e_ill = !ok;
        e_rd = legal && dr;
        e_wr = ok && dw && !(ELIDE && !rw && nv == old);
        e_wdata = nv;
        e_data = (ok && dr) ? old : 32'd0;
        e_lat = !legal ? 1 : !ok ? 2 : 2 + int'(dr) + int'(e_wr);
        dropped = legal && (flush_at == 1 || (flush_at == 2 && ok && dr));
        if (e_wr && !dropped) model_csr[a] = nv;
        @(negedge clock_i);
        req_valid_i = 1; req_funct3_i = f; req_address_i = a;
        req_rs1_data_i = d; req_rs1_field_i = fld; req_rd_is_x0_i = x0;
        @(posedge clock_i); #1;
        req_valid_i = 0; req_funct3_i = 3'($urandom); req_address_i = 12'($urandom);
        req_rs1_data_i = $urandom; req_rs1_field_i = 5'($urandom); req_rd_is_x0_i = 1'($urandom);
        busy = 1; cyc = 0; n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clock_i);
            n++;
            flush_i = (n == flush_at);
            if (dropped && n == flush_at) begin
                @(posedge clock_i); #1;
                flush_i = 0; busy = 0;
                chk("csr_value_after_flush", env_mem[a], model_csr[a]);
                return;
            end
            got = rsp_valid_o;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL rsp_timeout: rsp_valid_o stayed 0 for 20 cycles, required by cycle %0d", e_lat);
            flush_i = 0;
            apply_reset();
            return;
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clock_i);
            flush_i = 0;
        end
        rsp_ready_i = 1;
        @(posedge clock_i); #1;
        rsp_ready_i = 0; flush_i = 0; busy = 0;
        chk("csr_value", env_mem[a], model_csr[a]);
    endtask

    int w0;

    initial begin
        for (int i = 0; i < 8; i++) env_exists[addr_tab[i]] = addr_tab[i] != 12'h7C0;
        #2 reset_i = 1;
        #1;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_illegal", rsp_illegal_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_write_data", csr_write_data_o, 0);
        chk("rst_address", csr_address_o, 0);
        chk("rst_command", csr_command_o, C_NONE);
        repeat (2) @(posedge clock_i);
        #2 reset_i = 0;
        for (int i = 0; i < 8; i++) set_csr(addr_tab[i], $urandom);

        set_csr(12'h340, 32'h12345678);
        w0 = wr_count;
        run_op(3'b001, 12'h340, 32'hDEADBEEF, 5'd7, 0, 0, 0);
        chk("t_rw_lat", e_lat, 4);
        chk("t_rw_data", e_data, 32'h12345678);
        chk("t_rw_writes", wr_count - w0, 1);
        chk("t_rw_mem", env_mem[12'h340], 32'hDEADBEEF);

        set_csr(12'h304, 32'h800);
        w0 = wr_count;
        run_op(3'b010, 12'h304, 32'h88, 5'd9, 0, 0, 0);
        chk("t_rs_lat", e_lat, 4);
        chk("t_rs_data", e_data, 32'h800);
        chk("t_rs_mem", env_mem[12'h304], 32'h888);

        w0 = wr_count;
        run_op(3'b010, 12'h304, 32'hFFFFFFFF, 5'd0, 0, 0, 0);
        chk("t_rs0_lat", e_lat, 3);
        chk("t_rs0_writes", wr_count - w0, 0);
        chk("t_rs0_data", e_data, 32'h888);

        set_csr(12'h304, 32'h800);
        w0 = wr_count;
        run_op(3'b111, 12'h304, $urandom, 5'd4, 0, 0, 0);
        chk("t_elide_lat", e_lat, ELIDE ? 3 : 4);
        chk("t_elide_writes", wr_count - w0, ELIDE ? 0 : 1);
        chk("t_elide_mem", env_mem[12'h304], 32'h800);

        w0 = wr_count;
        run_op(3'b010, 12'h7C0, 32'h0, 5'd0, 0, 0, 0);
        chk("t_nx_lat", e_lat, 2);
        chk("t_nx_ill", e_ill, 1);
        run_op(3'b001, 12'hF14, 32'h55, 5'd1, 0, 0, 0);
        chk("t_ro_rw_ill", e_ill, 1);
        run_op(3'b010, 12'hF14, 32'h3, 5'd3, 0, 0, 0);
        chk("t_ro_rs_ill", e_ill, 1);
        chk("t_ill_writes", wr_count - w0, 0);
        run_op(3'b010, 12'hF14, 32'h3, 5'd0, 0, 0, 0);
        chk("t_ro_read_lat", e_lat, 3);
        run_op(3'b000, 12'h340, 32'h1, 5'd1, 0, 0, 0);
        chk("t_f000_lat", e_lat, 1);
        run_op(3'b100, 12'h340, 32'h1, 5'd1, 0, 0, 1);
        chk("t_f100_ill", e_ill, 1);

        w0 = wr_count;
        run_op(3'b010, 12'h304, 32'h1, 5'd1, 0, 2, 0);
        chk("t_flush_writes", wr_count - w0, 0);
        chk("t_flush_mem", env_mem[12'h304], 32'h800);

        set_csr(12'h340, 32'hDEADBEEF);
        run_op(3'b011, 12'h340, 32'hFFFF0000, 5'd2, 0, 0, 5);
        chk("t_stall_mem", env_mem[12'h340], 32'h0000BEEF);
        run_op(3'b101, 12'h340, 32'h0, 5'd17, 1, 0, 0);
        chk("t_wo_lat", e_lat, 3);
        chk("t_wo_mem", env_mem[12'h340], 32'd17);

        // Flush while idle must block the acceptance
        @(negedge clock_i);
        req_valid_i = 1; req_funct3_i = 3'b001; req_address_i = 12'h340; flush_i = 1;
        @(posedge clock_i); #1;
        req_valid_i = 0; flush_i = 0;
        repeat (3) @(negedge clock_i);

        // Reset asserted while WRITE_ONLY is on the bus
        e_addr = 12'h340; e_rd = 1; e_wr = 1; e_lat = 4; e_ill = 0;
        e_wdata = 32'hCAFEF00D; e_data = model_csr[12'h340];
        w0 = wr_count;
        @(negedge clock_i);
        req_valid_i = 1; req_funct3_i = 3'b001; req_rs1_data_i = 32'hCAFEF00D; req_rd_is_x0_i = 0;
        @(posedge clock_i); #1;
        req_valid_i = 0; busy = 1; cyc = 0;
        repeat (3) @(negedge clock_i);
        #2 reset_i = 1; busy = 0;
        #1;
        chk("t_rst_cmd", csr_command_o, C_NONE);
        chk("t_rst_ready", req_ready_o, 1);
        chk("t_rst_valid", rsp_valid_o, 0);
        @(posedge clock_i); #2;
        reset_i = 0;
        chk("t_rst_writes", wr_count - w0, 0);
        chk("t_rst_mem", env_mem[12'h340], 32'd17);

        for (int i = 0; i < 300; i++)
            run_op(3'($urandom), addr_tab[$urandom_range(0, 7)], $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0, int'($urandom_range(0, 2)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
